microcode_dispatch: RTL and testbench

MICROCODE_DISPATCH -- requirements
Module: microcode_dispatch

---
 rtl/fisc_dispatch_pkg.sv | 20 ++
 rtl/dispatch_fifo.sv | 62 ++++++
 rtl/fisc_defines.sv | 7 +
 rtl/microcode_dispatch.sv | 163 ++++++++++++++++
 tb/tb_microcode_dispatch.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fisc_dispatch_pkg.sv
// Types and constants shared by the microcode dispatch slice.
`ifndef R_FMT_OPCODE_SZ
`include "fisc_defines.sv"
`endif

package fisc_dispatch_pkg;

   localparam int unsigned OPCODE_W     = `R_FMT_OPCODE_SZ;
   // Consecutive eos-high cycles that close a segment.
   localparam int unsigned EOS_HIGH_RUN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_LOW,
      ST_WAIT_HIGH,
      ST_RETIRE
   } dispatch_state_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Opcode queue: power-of-two depth, synchronous flush, occupancy output.
module dispatch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned     PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign level   = count;
   assign rdata   = mem[rd_ptr];
   // Flush wins over both ports, so a push in the flush cycle is dropped.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fisc_defines.sv
// Shared FISC width definitions.
`ifndef FISC_DEFINES_SV
`define FISC_DEFINES_SV

`define R_FMT_OPCODE_SZ 12

`endif

// File: rtl/microcode_dispatch.sv
// Queues opcodes and sequences one microcode segment at a time (sos .. eos .. retire).
// Optional watchdog: define DISPATCH_WATCHDOG_EN.
`ifndef R_FMT_OPCODE_SZ
`include "fisc_defines.sv"
`endif

module microcode_dispatch
   import fisc_dispatch_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WDOG_LIMIT = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          instr_valid,
   input  logic [`R_FMT_OPCODE_SZ-1:0]   instr_opcode,
   output logic                          instr_ready,
   input  logic                          flush,
   output logic                          sos,
   output logic [`R_FMT_OPCODE_SZ-1:0]   microcode_opcode,
   input  logic                          ucode_eos,
   output logic                          busy,
   output logic                          retire,
   output logic [15:0]                   retire_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          wdog_err
);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       WDOG_LIMIT < 2) begin : g_bad_cfg
      $error("microcode_dispatch: unsupported FIFO_DEPTH or WDOG_LIMIT");
   end

   dispatch_state_t       state;
   dispatch_state_t       state_raw;
   dispatch_state_t       state_nxt;
   logic [1:0]            hi_cnt;
   logic [1:0]            hi_cnt_nxt;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [OPCODE_W-1:0]   fifo_head;
   logic                  waiting;
   logic                  wdog_trip;

   dispatch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (OPCODE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (instr_valid),
      .wdata (instr_opcode),
      .pop   (fifo_pop),
      .flush (flush),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign instr_ready = !fifo_full;
   assign sos         = (state == ST_ISSUE);
   assign retire      = (state == ST_RETIRE);
   assign busy        = (state != ST_IDLE);
   assign waiting     = (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);

   always_comb begin
      state_raw  = state;
      hi_cnt_nxt = hi_cnt;
      fifo_pop   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            // A flushed queue must not launch its head in the same cycle.
            if (!fifo_empty && !flush) begin
               fifo_pop  = 1'b1;
               state_raw = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_raw = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (!ucode_eos) begin
               state_raw  = ST_WAIT_HIGH;
               hi_cnt_nxt = '0;
            end
         end
         ST_WAIT_HIGH: begin
            if (ucode_eos) begin
               if (hi_cnt == 2'(EOS_HIGH_RUN - 1)) begin
                  state_raw = ST_RETIRE;
               end else begin
                  hi_cnt_nxt = hi_cnt + 2'd1;
               end
            end else begin
               hi_cnt_nxt = '0;
            end
         end
         ST_RETIRE: begin
            state_raw = ST_IDLE;
         end
         default: begin
            state_raw = ST_IDLE;
         end
      endcase
   end

   assign state_nxt = wdog_trip ? ST_IDLE : state_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         hi_cnt           <= '0;
         microcode_opcode <= '0;
         retire_count     <= '0;
      end else begin
         state  <= state_nxt;
         hi_cnt <= hi_cnt_nxt;
         if (fifo_pop) begin
            microcode_opcode <= fifo_head;
         end
         if (state == ST_RETIRE) begin
            retire_count <= retire_count + 16'd1;
         end
      end
   end

`ifdef DISPATCH_WATCHDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              wdog_err_q;

   // A segment that completes on the limit cycle still retires normally.
   assign wdog_trip = waiting && (state_raw != ST_RETIRE) &&
                      (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));
   assign wdog_err  = wdog_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt   <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         if (state == ST_ISSUE) begin
            wdog_cnt <= '0;
         end else if (waiting) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
         end
         if (wdog_trip) begin
            wdog_err_q <= 1'b1;
         end
      end
   end
`else
   logic unused_waiting;

   assign unused_waiting = waiting;
   assign wdog_trip      = 1'b0;
   assign wdog_err       = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_dispatch.sv
// Directed bench for microcode_dispatch with a queue-level reference model checked every cycle.
module tb_microcode_dispatch;
   import fisc_dispatch_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LIMIT = 255;
   localparam int unsigned OW    = OPCODE_W;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    instr_valid = 1'b0;
   logic [OW-1:0]           instr_opcode = '0;
   logic                    flush = 1'b0;
   logic                    ucode_eos = 1'b1;
   logic                    instr_ready;
   logic                    sos;
   logic [OW-1:0]           microcode_opcode;
   logic                    busy;
   logic                    retire;
   logic [15:0]             retire_count;
   logic [$clog2(DEPTH):0]  fifo_level;
   logic                    wdog_err;

   microcode_dispatch #(
      .FIFO_DEPTH (DEPTH),
      .WDOG_LIMIT (LIMIT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .instr_valid      (instr_valid),
      .instr_opcode     (instr_opcode),
      .instr_ready      (instr_ready),
      .flush            (flush),
      .sos              (sos),
      .microcode_opcode (microcode_opcode),
      .ucode_eos        (ucode_eos),
      .busy             (busy),
      .retire           (retire),
      .retire_count     (retire_count),
      .fifo_level       (fifo_level),
      .wdog_err         (wdog_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int dut_retires = 0;
   int dut_sos     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: opcode queue plus the life of the current segment.
   logic [OW-1:0] mq[$];
   bit            m_on   = 1'b0;
   bit            m_live = 1'b0;
   bit            m_sos  = 1'b0;
   bit            m_ret  = 1'b0;
   bit            m_low  = 1'b0;
   bit            m_wdog = 1'b0;
   int            m_run  = 0;
   int            m_wait = 0;
   logic [OW-1:0] m_op   = '0;
   logic [15:0]   m_cnt  = '0;

   task automatic model_step();
      bit ready_pre;
      bit do_pop;
      if (rst) begin
         mq.delete();
         m_on = 1'b1; m_live = 1'b0; m_sos = 1'b0; m_ret = 1'b0; m_low = 1'b0;
         m_wdog = 1'b0; m_run = 0; m_wait = 0; m_op = '0; m_cnt = '0;
      end else if (m_on) begin
         ready_pre = (mq.size() < DEPTH);
         do_pop    = !m_live && (mq.size() != 0) && !flush;
         if (m_live) begin
            if (m_ret) begin
               m_live = 1'b0; m_ret = 1'b0; m_cnt = m_cnt + 16'd1;
            end else if (m_sos) begin
               m_sos = 1'b0; m_low = 1'b0; m_run = 0; m_wait = 0;
            end else begin
               // Ends on the second consecutive high after at least one low.
               if (!m_low) begin
                  m_low = !ucode_eos;
               end else begin
                  m_run = ucode_eos ? m_run + 1 : 0;
                  if (m_run == 2) m_ret = 1'b1;
               end
`ifdef DISPATCH_WATCHDOG_EN
               m_wait++;
               if (!m_ret && m_wait == LIMIT) begin
                  m_live = 1'b0; m_wdog = 1'b1;
               end
`endif
            end
         end
         if (do_pop) begin
            m_op = mq.pop_front(); m_live = 1'b1; m_sos = 1'b1;
         end
         if (flush) mq.delete();
         else if (instr_valid && ready_pre) mq.push_back(instr_opcode);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (sos === 1'b1) dut_sos++;
      if (retire === 1'b1) dut_retires++;
      if (m_on) begin
         chk("m_sos",    sos,              m_live && m_sos);
         chk("m_busy",   busy,             m_live);
         chk("m_retire", retire,           m_ret);
         chk("m_count",  retire_count,     m_cnt);
         chk("m_level",  fifo_level,       mq.size());
         chk("m_ready",  instr_ready,      mq.size() < DEPTH);
         chk("m_opcode", microcode_opcode, m_op);
         chk("m_wdog",   wdog_err,         m_wdog);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [OW-1:0] op);
      instr_valid  = 1'b1;
      instr_opcode = op;
      step();
      instr_valid  = 1'b0;
   endtask

   // pat bit i is the eos value for the i-th cycle; retire must appear only after the last.
   task automatic run_pattern(input string tag, input int unsigned len, input logic [7:0] pat);
      for (int unsigned i = 0; i < len; i++) begin
         ucode_eos = pat[i];
         step();
         chk(tag, retire, (i == len - 1));
      end
      ucode_eos = 1'b1;
   endtask

   initial begin
      int sos_before;
      int ret_before;

      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_ready", instr_ready, 1);
      chk("rst_busy",  busy, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_count", retire_count, 0);
      chk("rst_opc",   microcode_opcode, 0);

      // Single segment, eos 1,1,0,1,1.
      push_one(12'h123);
      chk("a_level_n1", fifo_level, 1);
      chk("a_sos_n1",   sos, 0);
      step();
      chk("a_sos_n2",   sos, 1);
      chk("a_opcode",   microcode_opcode, 12'h123);
      step();
      run_pattern("a_retire", 5, 8'b0001_1011);
      step();
      chk("a_count",    retire_count, 1);
      chk("a_pulses",   dut_retires, 1);
      chk("a_idle",     busy, 0);

      // Multi-row segment, eos 0,0,1,0,1,1.
      push_one(12'h2A5);
      step();
      chk("b_sos",      sos, 1);
      chk("b_opcode",   microcode_opcode, 12'h2A5);
      step();
      run_pattern("b_retire", 6, 8'b0011_0100);
      step();
      chk("b_count",    retire_count, 2);
      chk("b_pulses",   dut_retires, 2);

      // Hang a segment, then fill the queue; the fifth opcode is held off.
      push_one(12'h0F0);
      step();
      chk("c_sos",      sos, 1);
      for (int unsigned k = 0; k < 4; k++) begin
         instr_valid  = 1'b1;
         instr_opcode = OW'(12'h101 + k);
         chk("c_ready_open", instr_ready, 1);
         step();
      end
      instr_opcode = 12'h105;
      for (int unsigned k = 0; k < 3; k++) begin
         chk("c_ready_full", instr_ready, 0);
         chk("c_level_full", fifo_level, 4);
         step();
      end
      instr_valid = 1'b0;
      chk("c_busy",     busy, 1);

      // Finish 0x0F0, launch 0x101, then flush the other three with a colliding push.
      run_pattern("d_retire", 3, 8'b0000_0110);
      step();
      step();
      chk("d_sos",      sos, 1);
      chk("d_opcode",   microcode_opcode, 12'h101);
      chk("d_level",    fifo_level, 3);
      flush        = 1'b1;
      instr_valid  = 1'b1;
      instr_opcode = 12'h1FF;
      step();
      flush       = 1'b0;
      instr_valid = 1'b0;
      chk("d_flush_level", fifo_level, 0);
      chk("d_flush_ready", instr_ready, 1);
      chk("d_inflight",    busy, 1);
      run_pattern("d_flush_retire", 4, 8'b0000_1101);
      sos_before = dut_sos;
      for (int unsigned k = 0; k < 8; k++) begin
         step();
         chk("d_no_sos", sos, 0);
      end
      chk("d_sos_total", dut_sos, sos_before);
      chk("d_count",     retire_count, 4);

      // Reset while in the eos-high wait with two opcodes queued.
      push_one(12'h0AA);
      step();
      chk("e_sos", sos, 1);
      ucode_eos = 1'b0;
      push_one(12'h0BB);
      push_one(12'h0CC);
      chk("e_level_pre", fifo_level, 2);
      chk("e_busy_pre",  busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      ucode_eos = 1'b1;
      chk("e_sos0",    sos, 0);
      chk("e_busy0",   busy, 0);
      chk("e_retire0", retire, 0);
      chk("e_opc0",    microcode_opcode, 0);
      chk("e_count0",  retire_count, 0);
      chk("e_level0",  fifo_level, 0);
      chk("e_ready1",  instr_ready, 1);
      chk("e_wdog0",   wdog_err, 0);

      // eos held high after sos: watchdog timeout or indefinite wait.
      push_one(12'h3C3);
      step();
      chk("f_sos", sos, 1);
      ret_before = dut_retires;
      for (int unsigned k = 0; k < LIMIT; k++) step();
      chk("f_wdog_pre", wdog_err, 0);
      chk("f_busy_pre", busy, 1);
      step();
`ifdef DISPATCH_WATCHDOG_EN
      chk("f_wdog_set",  wdog_err, 1);
      chk("f_busy_idle", busy, 0);
      for (int unsigned k = 0; k < 4; k++) step();
      chk("f_wdog_sticky", wdog_err, 1);
`else
      chk("f_wdog_off",  wdog_err, 0);
      chk("f_busy_hold", busy, 1);
`endif
      chk("f_no_retire", dut_retires, ret_before);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("f_wdog_rst", wdog_err, 0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
